// File: rtl/instr_fetch_unit.sv
//==============================================================================
// Module   : instr_fetch_unit
// Brief    : IF stage with stall hold buffer and flush drain of in-flight fetch
// Revision : 1.0
//==============================================================================
`default_nettype none

module instr_fetch_unit #(
    parameter int ADDR_W  = 16,
    parameter int INSTR_W = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [ADDR_W-1:0]  pc_in,
    output logic               pc_stall,
    input  logic               stall_in,
    input  logic               flush_in,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ready,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               if_valid,
    output logic [INSTR_W-1:0] if_instr,
    output logic [ADDR_W-1:0]  if_pc,
    output logic [15:0]        fetch_count
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic               if_valid_q, if_valid_d;
    logic [INSTR_W-1:0] if_instr_q, if_instr_d;
    logic [ADDR_W-1:0]  if_pc_q, if_pc_d;
    logic [15:0]        fetch_count_q, fetch_count_d;
    logic [INSTR_W-1:0] hold_instr_q, hold_instr_d;
    logic [ADDR_W-1:0]  hold_pc_q, hold_pc_d;
    logic [ADDR_W-1:0]  drain_addr_q, drain_addr_d;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= FETCH;
            if_valid_q    <= 1'b0;
            if_instr_q    <= '0;
            if_pc_q       <= '0;
            fetch_count_q <= '0;
            hold_instr_q  <= '0;
            hold_pc_q     <= '0;
            drain_addr_q  <= '0;
        end else begin
            state_q       <= state_d;
            if_valid_q    <= if_valid_d;
            if_instr_q    <= if_instr_d;
            if_pc_q       <= if_pc_d;
            fetch_count_q <= fetch_count_d;
            hold_instr_q  <= hold_instr_d;
            hold_pc_q     <= hold_pc_d;
            drain_addr_q  <= drain_addr_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        if_valid_d    = if_valid_q;
        if_instr_d    = if_instr_q;
        if_pc_d       = if_pc_q;
        fetch_count_d = fetch_count_q;
        hold_instr_d  = hold_instr_q;
        hold_pc_d     = hold_pc_q;
        drain_addr_d  = drain_addr_q;
        pc_stall      = 1'b0;
        imem_req      = (state_q != HOLD);
        imem_addr     = pc_in;

        // An unstalled decode stage with nothing new to consume sees a bubble.
        unique case (state_q)
            FETCH: begin
                if (flush_in) begin
                    if_valid_d = 1'b0;
                    if (!imem_ready) begin
                        drain_addr_d = pc_in;
                        state_d      = DRAIN;
                    end
                end else if (imem_ready && !stall_in) begin
                    if_valid_d    = 1'b1;
                    if_instr_d    = imem_rdata;
                    if_pc_d       = pc_in;
                    fetch_count_d = fetch_count_q + 16'd1;
                end else if (imem_ready) begin
                    hold_instr_d = imem_rdata;
                    hold_pc_d    = pc_in;
                    state_d      = HOLD;
                    pc_stall     = 1'b1;
                end else begin
                    pc_stall = 1'b1;
                    if (!stall_in) if_valid_d = 1'b0;
                end
            end
            HOLD: begin
                if (flush_in) begin
                    if_valid_d = 1'b0;
                    state_d    = FETCH;
                end else if (!stall_in) begin
                    if_valid_d    = 1'b1;
                    if_instr_d    = hold_instr_q;
                    if_pc_d       = hold_pc_q;
                    fetch_count_d = fetch_count_q + 16'd1;
                    state_d       = FETCH;
                end else begin
                    pc_stall = 1'b1;
                end
            end
            DRAIN: begin
                imem_addr = drain_addr_q;
                if (flush_in) begin
                    if_valid_d = 1'b0;
                end else begin
                    pc_stall = 1'b1;
                    if (imem_ready) state_d = FETCH;
                    if (!stall_in) if_valid_d = 1'b0;
                end
            end
            default: begin
                state_d = FETCH;
            end
        endcase

        if (!reset) begin
            pc_stall = 1'b0;
            imem_req = 1'b0;
        end
    end

    assign if_valid    = if_valid_q;
    assign if_instr    = if_instr_q;
    assign if_pc       = if_pc_q;
    assign fetch_count = fetch_count_q;

endmodule

`default_nettype wire

// File: doc/instr_fetch_unit.md
INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- ADDR_W, 16, PC/instruction-memory address width.
- INSTR_W, 32, instruction width.
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk  in  1  single clock; all state changes on rising edge.
- reset  in  1  synchronous, active-low reset.
- pc_in  in  ADDR_W  current PC from PC register.
- pc_stall  out  1  drives PC register nop; 1 = hold PC.
- stall_in  in  1  decode-stage stall; 1 = hold IF/ID.
- flush_in  in  1  taken branch/jump; discard fetched or in-flight instruction.
- imem_req  out  1  instruction memory request.
- imem_addr  out  ADDR_W  request address; held stable while imem_req=1 and imem_ready=0.
- imem_ready  in  1  memory completes the request this cycle.
- imem_rdata  in  INSTR_W  instruction; valid only when imem_ready=1.
- if_valid  out  1  IF/ID register holds a valid instruction.
- if_instr  out  INSTR_W  IF/ID instruction.
- if_pc  out  ADDR_W  PC of if_instr.
- fetch_count  out  16  number of instructions loaded into IF/ID.

Function
REQ-003 The FSM SHALL have states FETCH, HOLD and DRAIN, with FETCH as the reset state.
REQ-004 imem_req SHALL be 1 in FETCH and DRAIN, 0 in HOLD, and 0 while reset=0.
REQ-005 imem_addr SHALL be pc_in in FETCH and drain_addr (register) in DRAIN.
REQ-006 The request SHALL complete in the cycle in which imem_req=1 and imem_ready=1; there SHALL be no other handshake.
REQ-007 Accept condition SHALL be: FETCH, imem_ready=1, stall_in=0, flush_in=0; on accept, the next edge SHALL load if_valid=1, if_instr=imem_rdata and if_pc=pc_in; pc_stall SHALL be 0 and the FSM SHALL stay in FETCH.
REQ-008 In FETCH with imem_ready=1, stall_in=1 and flush_in=0, the unit SHALL capture imem_rdata and pc_in into the hold buffer, go to HOLD and drive pc_stall=1.
REQ-009 In FETCH with imem_ready=0 and flush_in=0, the unit SHALL drive pc_stall=1 and stay in FETCH.
REQ-010 In HOLD with stall_in=0 and flush_in=0, the unit SHALL move the hold buffer to IF/ID (if_valid=1), drive pc_stall=0 and go to FETCH.
REQ-011 In HOLD with stall_in=1, the unit SHALL drive pc_stall=1 and keep both IF/ID and the hold buffer unchanged.
REQ-012 When flush_in=1, pc_stall SHALL be 0 in every state, so the PC register loads the target.
REQ-013 When flush_in=1, the next edge SHALL set if_valid=0, regardless of stall_in.
REQ-014 Flush in FETCH with imem_ready=1 SHALL discard imem_rdata and keep the FSM in FETCH.
REQ-015 Flush in FETCH with imem_ready=0 SHALL latch drain_addr=pc_in and go to DRAIN.
REQ-016 Flush in HOLD SHALL discard the hold buffer and go to FETCH.
REQ-017 In DRAIN, the unit SHALL keep the request at drain_addr until imem_ready=1, then discard imem_rdata and go to FETCH; pc_stall SHALL be 1 unless flush_in=1.
REQ-018 A flush in DRAIN SHALL keep the FSM in DRAIN with drain_addr unchanged.
REQ-019 When stall_in=1 and no new instruction is loaded, IF/ID SHALL hold its value, including while if_valid=0.
REQ-020 pc_stall SHALL be combinational from state, imem_ready, stall_in and flush_in, with no registered delay.
REQ-021 fetch_count SHALL increment by 1 on each load of IF/ID with if_valid=1 (REQ-007, REQ-010) and wrap from 0xFFFF to 0x0000.
REQ-022 With imem_ready tied to 1 and no stall or flush, throughput SHALL be one instruction per cycle with one-cycle latency from pc_in to if_instr.

Reset
REQ-023 While reset=0 at a rising edge, the unit SHALL set state=FETCH, if_valid=0, if_instr=0, if_pc=0, fetch_count=0, hold buffer=0 and drain_addr=0.
REQ-024 While reset=0, pc_stall SHALL be 0 and imem_req SHALL be 0.
REQ-025 A reset asserted mid-request SHALL abandon the request; the first request after release SHALL use pc_in.

Verification
REQ-026 The bench SHALL cover these scenarios, one per line as stimulus -> required response:
- reset=0 for 2 cycles, then imem_ready=1, pc_in sequence 0,1,2 -> if_pc 0,1,2 on consecutive cycles, pc_stall=0, fetch_count=3.
- imem_ready=0 for 3 cycles at pc_in=0x0010, then 1 with rdata=0xDEADBEEF -> pc_stall=1 for 3 cycles, imem_addr stable at 0x0010, if_instr=0xDEADBEEF.
- stall_in=1 while ready at pc_in=0x0004 for 2 cycles, then stall_in=0 -> HOLD; IF/ID unchanged; then if_pc=0x0004 and pc_stall=0 in release cycle.
- flush_in=1 while waiting at pc_in=0x0020 (ready=0), pc_in then 0x0100 -> DRAIN with imem_addr=0x0020 until ready; rdata dropped; if_valid=0; next request at 0x0100.
- flush_in=1 and stall_in=1 in HOLD -> if_valid=0, hold buffer discarded, FETCH, pc_stall=0.
- fetch_count preset by 0xFFFF accepts -> one more accept gives 0x0000.
